// File: rtl/apb4_mst_pkg.sv
`default_nettype none
// ============================================================================
// apb4_mst_pkg : shared types and default widths for apb4_master_bridge
// Rev 1.0 : initial release
// ============================================================================
package apb4_mst_pkg;

  localparam int unsigned DEF_ADDR_W         = 32;
  localparam int unsigned DEF_DATA_W         = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

  // Storage widths for the command/response structs; instance widths must not exceed these.
  localparam int unsigned MAX_ADDR_W = 32;
  localparam int unsigned MAX_DATA_W = 32;
  localparam int unsigned MAX_STRB_W = MAX_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic                  write;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] wdata;
    logic [MAX_STRB_W-1:0] strb;
    logic [2:0]            prot;
  } cmd_t;

  typedef struct packed {
    logic [MAX_DATA_W-1:0] rdata;
    logic                  err;
  } rsp_t;

endpackage
`default_nettype wire

// File: rtl/apb4_master_bridge.sv
`default_nettype none
// ============================================================================
// apb4_master_bridge : valid/ready command stream to APB4 master, one transfer at a time
// Optional: define APB_MST_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states
// Rev 1.0 : initial release
// ============================================================================
module apb4_master_bridge
  import apb4_mst_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  input  logic [2:0]          cmd_prot,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [2:0]          PPROT,
  output logic                PSELx,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  input  logic                PREADY,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PSLVERR
);

  localparam int unsigned STRB_W = DATA_W / 8;

  state_e state_q, state_d;
  cmd_t   cmd_q, cmd_d;
  rsp_t   rsp_q, rsp_d;
  logic   psel_q, psel_d;
  logic   penable_q, penable_d;
  logic   cmd_ready_q, cmd_ready_d;
  logic   xfer_done;

`ifdef APB_MST_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_q, wait_d;
`endif

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    rsp_d     = rsp_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    xfer_done = 1'b0;
`ifdef APB_MST_TIMEOUT_EN
    wait_d    = wait_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_d.write = cmd_write;
          cmd_d.addr  = MAX_ADDR_W'(cmd_addr);
          cmd_d.wdata = MAX_DATA_W'(cmd_wdata);
          // Read strobes are forced low at capture so PSTRB comes straight from a flop.
          cmd_d.strb  = cmd_write ? MAX_STRB_W'(cmd_strb) : '0;
          cmd_d.prot  = cmd_prot;
          psel_d      = 1'b1;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_MST_TIMEOUT_EN
        wait_d    = '0;
`endif
      end
      ACCESS: begin
        if (PREADY) begin
          rsp_d.rdata = cmd_q.write ? '0 : MAX_DATA_W'(PRDATA);
          rsp_d.err   = PSLVERR;
          xfer_done   = 1'b1;
        end
`ifdef APB_MST_TIMEOUT_EN
        else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
          rsp_d.rdata = '0;
          rsp_d.err   = 1'b1;
          xfer_done   = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (xfer_done) begin
      psel_d     = 1'b0;
      penable_d  = 1'b0;
      cmd_d.strb = '0;
      state_d    = RESP;
    end
    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      rsp_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      rsp_q       <= rsp_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

`ifdef APB_MST_TIMEOUT_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`endif

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_q.rdata[DATA_W-1:0];
  assign rsp_err   = rsp_q.err;
  assign PADDR     = cmd_q.addr[ADDR_W-1:0];
  assign PPROT     = cmd_q.prot;
  assign PSELx     = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = cmd_q.write;
  assign PWDATA    = cmd_q.wdata[DATA_W-1:0];
  assign PSTRB     = cmd_q.strb[STRB_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_apb4_master_bridge.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_apb4_master_bridge : randomized self-checking bench with a transaction-level model
// Rev 1.0 : initial release
// ============================================================================
module tb_apb4_master_bridge;

  localparam int TMO = 4;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic [2:0]  cmd_prot = '0;
  logic        cmd_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, PADDR, PWDATA;
  logic [2:0]  PPROT;
  logic        PSELx, PENABLE, PWRITE;
  logic [3:0]  PSTRB;
  logic        PREADY = 1'b0, PSLVERR = 1'b0;
  logic [31:0] PRDATA = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed {
    int          lat;
    int          setup_n;
    int          access_n;
    int          hs_cyc;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pwrite;
    logic        unstable;
    logic        busy_ready;
    logic        hold_bad;
    logic        rsp_after;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  idle_strb;
    logic [31:0] idle_paddr;
  } obs_t;

  apb4_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PPROT(PPROT), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc++;

  // Transaction-level expectation: waits<0 means the slave never answers.
  function automatic void model(input logic wr, input logic [3:0] strb, input int waits,
                                input logic [31:0] rdat, input logic serr,
                                output int e_access, output int e_lat,
                                output logic [31:0] e_rdata, output logic e_err,
                                output logic [3:0] e_strb);
    bit tmo;
    tmo = 1'b0;
`ifdef APB_MST_TIMEOUT_EN
    tmo = (waits < 0) || (waits >= TMO);
`endif
    e_strb = wr ? strb : 4'h0;
    if (tmo) begin
      e_access = TMO; e_rdata = 32'h0; e_err = 1'b1;
    end else begin
      e_access = waits + 1; e_rdata = wr ? 32'h0 : rdat; e_err = serr;
    end
    e_lat = e_access + 2;
  endfunction

  // Issues one command, plays the slave, then holds the response for `hold` cycles.
  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot, input int waits,
                          input logic [31:0] rdat, input logic serr, input logic serr_wait,
                          input int hold, output obs_t o);
    int c;
    o = '0;
    o.lat = -1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    cmd_strb = strb; cmd_prot = prot;
    c = 0;
    while (cmd_ready !== 1'b1 && c < 20) begin @(posedge PCLK); #1; c++; end
    o.hs_cyc = cyc;
    @(posedge PCLK); #1;
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = $urandom;
    cmd_strb = $urandom; cmd_prot = $urandom;
    for (c = 1; c < 200; c++) begin
      if (cmd_ready === 1'b1) o.busy_ready = 1'b1;
      if (rsp_valid === 1'b1) begin o.lat = c; break; end
      if (PSELx && !PENABLE) begin
        o.setup_n++;
        o.paddr = PADDR; o.pwdata = PWDATA; o.pstrb = PSTRB; o.pprot = PPROT; o.pwrite = PWRITE;
        PREADY = $urandom; PSLVERR = $urandom; PRDATA = $urandom;
      end else if (PSELx && PENABLE) begin
        o.access_n++;
        if ({PADDR, PWDATA, PSTRB, PPROT, PWRITE} !== {o.paddr, o.pwdata, o.pstrb, o.pprot, o.pwrite})
          o.unstable = 1'b1;
        PREADY  = (waits >= 0) && (o.access_n == waits + 1);
        PSLVERR = PREADY ? serr : serr_wait;
        PRDATA  = PREADY ? rdat : $urandom;
      end else begin
        PREADY = 1'b0; PSLVERR = 1'b0;
      end
      @(posedge PCLK); #1;
    end
    PREADY = 1'b0; PSLVERR = 1'b0;
    o.rdata = rsp_rdata; o.err = rsp_err;
    if (o.lat < 0) return;
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'b1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== o.rdata || rsp_err !== o.err ||
          cmd_ready !== 1'b0 || PSELx !== 1'b0) o.hold_bad = 1'b1;
      @(posedge PCLK); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    rsp_ready = 1'b0;
    o.rsp_after = rsp_valid; o.idle_strb = PSTRB; o.idle_paddr = PADDR;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge PCLK);
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PPROT, PSELx, PENABLE, PWRITE, PWDATA, PSTRB} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got cmd_ready=%b rsp_valid=%b psel=%b penable=%b paddr=%h pstrb=%h exp all zero",
               cmd_ready, rsp_valid, PSELx, PENABLE, PADDR, PSTRB);
    end
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    checks++;
    if ({cmd_ready, rsp_valid, PSELx} !== 3'b100) begin
      failures++; $display("FAIL reset_release got ready/valid/psel=%b exp 100", {cmd_ready, rsp_valid, PSELx});
    end
  endtask

  task automatic test_write;
    obs_t o;
    run_xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b010, 0, 32'h5555_AAAA, 1'b0, 1'b0, 0, o);
    checks++; if (o.lat !== 3) begin failures++; $display("FAIL wr_latency got=%0d exp=3", o.lat); end
    checks++; if ({o.setup_n, o.access_n} !== {32'd1, 32'd1}) begin
      failures++; $display("FAIL wr_phases got setup=%0d access=%0d exp 1/1", o.setup_n, o.access_n); end
    checks++; if ({o.paddr, o.pwdata, o.pstrb, o.pprot, o.pwrite} !== {32'h10, 32'hDEAD_BEEF, 4'hF, 3'b010, 1'b1}) begin
      failures++; $display("FAIL wr_bus got addr=%h wdata=%h strb=%h prot=%b wr=%b", o.paddr, o.pwdata, o.pstrb, o.pprot, o.pwrite); end
    checks++; if ({o.rdata, o.err} !== 33'h0) begin
      failures++; $display("FAIL wr_rsp got rdata=%h err=%b exp 0/0", o.rdata, o.err); end
    checks++; if ({o.idle_strb, o.idle_paddr, o.rsp_after} !== {4'h0, 32'h10, 1'b0}) begin
      failures++; $display("FAIL wr_idle got strb=%h paddr=%h rsp_valid=%b exp 0/10/0", o.idle_strb, o.idle_paddr, o.rsp_after); end
  endtask

  task automatic test_read_waits;
    obs_t o;
    run_xfer(1'b0, 32'h0000_0020, 32'hFFFF_0000, 4'hB, 3'b001, 3, 32'h1234_5678, 1'b0, 1'b0, 0, o);
    checks++; if (o.access_n !== 4) begin failures++; $display("FAIL rd_penable_cycles got=%0d exp=4", o.access_n); end
    checks++; if (o.pstrb !== 4'h0) begin failures++; $display("FAIL rd_pstrb got=%h exp=0", o.pstrb); end
    checks++; if ({o.rdata, o.err} !== {32'h1234_5678, 1'b0}) begin
      failures++; $display("FAIL rd_rsp got rdata=%h err=%b exp 12345678/0", o.rdata, o.err); end
    checks++; if ({o.lat, o.unstable} !== {32'd6, 1'b0}) begin
      failures++; $display("FAIL rd_timing got lat=%0d unstable=%b exp 6/0", o.lat, o.unstable); end
  endtask

  task automatic test_slverr;
    obs_t o;
    run_xfer(1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'h3, 3'b000, 2, 32'h7777_7777, 1'b1, 1'b0, 0, o);
    checks++; if ({o.rdata, o.err} !== {32'h0, 1'b1}) begin
      failures++; $display("FAIL slverr_rsp got rdata=%h err=%b exp 0/1", o.rdata, o.err); end
    run_xfer(1'b0, 32'h0000_0034, 32'h0, 4'h0, 3'b100, 2, 32'h0BAD_CAFE, 1'b0, 1'b1, 0, o);
    checks++; if ({o.rdata, o.err} !== {32'h0BAD_CAFE, 1'b0}) begin
      failures++; $display("FAIL slverr_wait_ignored got rdata=%h err=%b exp 0badcafe/0", o.rdata, o.err); end
  endtask

  task automatic test_backpressure;
    obs_t o;
    run_xfer(1'b0, 32'h0000_0044, 32'h0, 4'h0, 3'b011, 1, 32'hA5A5_5A5A, 1'b0, 1'b0, 5, o);
    checks++; if (o.hold_bad !== 1'b0) begin failures++; $display("FAIL bp_hold got bad=%b exp 0", o.hold_bad); end
    checks++; if ({o.rdata, o.rsp_after} !== {32'hA5A5_5A5A, 1'b0}) begin
      failures++; $display("FAIL bp_rsp got rdata=%h rsp_after=%b exp a5a55a5a/0", o.rdata, o.rsp_after); end
    run_xfer(1'b1, 32'h0000_0048, 32'h0102_0304, 4'h6, 3'b000, 0, 32'h0, 1'b0, 1'b0, 0, o);
    checks++; if ({o.lat, o.paddr} !== {32'd3, 32'h48}) begin
      failures++; $display("FAIL bp_next got lat=%0d addr=%h exp 3/48", o.lat, o.paddr); end
  endtask

  task automatic test_back_to_back;
    obs_t o;
    int prev;
    run_xfer(1'b1, 32'h100, 32'h1, 4'h1, 3'b0, 0, 32'h0, 1'b0, 1'b0, 0, o);
    prev = o.hs_cyc;
    for (int i = 0; i < 2; i++) begin
      run_xfer(1'b0, 32'h104 + i, 32'h0, 4'h0, 3'b0, 0, 32'h1111 * (i + 1), 1'b0, 1'b0, 0, o);
      checks++; if (o.hs_cyc - prev !== 4) begin
        failures++; $display("FAIL b2b_spacing[%0d] got=%0d exp=4", i, o.hs_cyc - prev); end
      prev = o.hs_cyc;
    end
  endtask

  task automatic test_random;
    obs_t o;
    logic wr, serr, serr_w;
    logic [31:0] addr, wdata, rdat, e_rdata;
    logic [3:0] strb, e_strb;
    logic [2:0] prot;
    logic e_err;
    int waits, hold, e_access, e_lat;
    for (int i = 0; i < 25; i++) begin
      wr = $urandom; addr = $urandom; wdata = $urandom; rdat = $urandom; strb = $urandom;
      prot = $urandom; serr = $urandom; serr_w = $urandom;
      waits = $urandom_range(0, 3); hold = $urandom_range(0, 2);
      model(wr, strb, waits, rdat, serr, e_access, e_lat, e_rdata, e_err, e_strb);
      run_xfer(wr, addr, wdata, strb, prot, waits, rdat, serr, serr_w, hold, o);
      checks++; if ({o.lat, o.setup_n, o.access_n} !== {e_lat, 32'd1, e_access}) begin
        failures++; $display("FAIL rnd_timing[%0d] got lat=%0d setup=%0d access=%0d exp %0d/1/%0d",
                             i, o.lat, o.setup_n, o.access_n, e_lat, e_access); end
      checks++; if ({o.paddr, o.pwdata, o.pstrb, o.pprot, o.pwrite} !== {addr, wdata, e_strb, prot, wr}) begin
        failures++; $display("FAIL rnd_bus[%0d] got addr=%h wdata=%h strb=%h exp addr=%h wdata=%h strb=%h",
                             i, o.paddr, o.pwdata, o.pstrb, addr, wdata, e_strb); end
      checks++; if ({o.rdata, o.err} !== {e_rdata, e_err}) begin
        failures++; $display("FAIL rnd_rsp[%0d] got rdata=%h err=%b exp rdata=%h err=%b", i, o.rdata, o.err, e_rdata, e_err); end
      checks++; if ({o.unstable, o.busy_ready, o.hold_bad, o.rsp_after, o.idle_strb} !== 8'h0) begin
        failures++; $display("FAIL rnd_proto[%0d] got unstable=%b busy_ready=%b hold_bad=%b rsp_after=%b idle_strb=%h exp all 0",
                             i, o.unstable, o.busy_ready, o.hold_bad, o.rsp_after, o.idle_strb); end
    end
  endtask

  task automatic test_async_reset;
    int c;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_strb = 4'hA; PREADY = 1'b0;
    c = 0;
    while (cmd_ready !== 1'b1 && c < 20) begin @(posedge PCLK); #1; c++; end
    @(posedge PCLK); #1; cmd_valid = 1'b0;
    @(posedge PCLK); #1;
    checks++; if ({PSELx, PENABLE} !== 2'b11) begin
      failures++; $display("FAIL arst_in_access got psel/penable=%b exp 11", {PSELx, PENABLE}); end
    @(posedge PCLK); #3;
    PRESETn = 1'b0;
    #1;
    checks++; if ({PSELx, PENABLE, rsp_valid, cmd_ready} !== 4'b0000) begin
      failures++; $display("FAIL arst_async got psel/penable/rsp_valid/cmd_ready=%b exp 0000",
                           {PSELx, PENABLE, rsp_valid, cmd_ready}); end
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    checks++; if ({cmd_ready, PSELx} !== 2'b10) begin
      failures++; $display("FAIL arst_idle got cmd_ready/psel=%b exp 10", {cmd_ready, PSELx}); end
    c = 0;
    repeat (4) begin
      if (rsp_valid !== 1'b0 || PSELx !== 1'b0) c++;
      PREADY = 1'b1;
      @(posedge PCLK); #1;
    end
    PREADY = 1'b0;
    checks++; if (c != 0) begin failures++; $display("FAIL arst_no_rsp got busy_cycles=%0d exp 0", c); end
  endtask

`ifdef APB_MST_TIMEOUT_EN
  task automatic test_timeout;
    obs_t o;
    int w [3];
    int e_access, e_lat;
    logic [31:0] e_rdata;
    logic e_err;
    logic [3:0] e_strb;
    w[0] = -1; w[1] = TMO - 1; w[2] = TMO;
    for (int i = 0; i < 3; i++) begin
      model(1'b0, 4'h0, w[i], 32'h3C3C_3C3C, 1'b0, e_access, e_lat, e_rdata, e_err, e_strb);
      run_xfer(1'b0, 32'h80 + i, 32'h0, 4'h0, 3'b0, w[i], 32'h3C3C_3C3C, 1'b0, 1'b0, 0, o);
      checks++; if ({o.access_n, o.lat} !== {e_access, e_lat}) begin
        failures++; $display("FAIL tmo_timing[%0d] got access=%0d lat=%0d exp %0d/%0d", i, o.access_n, o.lat, e_access, e_lat); end
      checks++; if ({o.rdata, o.err} !== {e_rdata, e_err}) begin
        failures++; $display("FAIL tmo_rsp[%0d] got rdata=%h err=%b exp rdata=%h err=%b", i, o.rdata, o.err, e_rdata, e_err); end
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write();
    test_read_waits();
    test_slverr();
    test_backpressure();
    test_back_to_back();
    test_random();
`ifdef APB_MST_TIMEOUT_EN
    test_timeout();
`endif
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb4_master_bridge.md
Name: apb4_master_bridge

Overview:
Converts a simple valid/ready command stream into APB4 transfers, one at a time. It drives the APB4 bus signals that the slave-side agent samples, and returns read data and error status on a valid/ready response channel. The block sits directly upstream of any APB4 slave and is the DUT-side master the slave agent is exercised against.

Parameters:
ADDR_W, 32, PADDR/cmd_addr width
DATA_W, 32, PWDATA/PRDATA width; legal values 8, 16, 32
TIMEOUT_CYCLES, 16, maximum ACCESS-phase wait states before abort (used only with the optional feature)

Ports:
PCLK  in  1  bus clock, all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  target address
cmd_wdata  in  DATA_W  write data
cmd_strb  in  DATA_W/8  write byte strobes
cmd_prot  in  3  protection attributes
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when valid&ready
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_err  out  1  PSLVERR or timeout
PADDR  out  ADDR_W  APB address
PPROT  out  3  APB protection
PSELx  out  1  slave select
PENABLE  out  1  access phase
PWRITE  out  1  direction
PWDATA  out  DATA_W  write data
PSTRB  out  DATA_W/8  write strobes
PREADY  in  1  slave ready
PRDATA  in  DATA_W  slave read data
PSLVERR  in  1  slave error

Behaviour:
- Clock PCLK; reset PRESETn is asynchronous, active-low.
- While PRESETn=0:
  - All outputs are 0.
  - FSM is in IDLE.
  - An assertion mid-transfer aborts it immediately: PSELx and PENABLE drop asynchronously and no response is issued.
- FSM states: IDLE, SETUP, ACCESS, RESP. All APB outputs are registered.
- IDLE:
  - cmd_ready=1; PSELx=PENABLE=0.
  - On cmd_valid&cmd_ready, capture addr, wdata, strb, prot and write, then go to SETUP.
- SETUP (exactly 1 cycle):
  - PSELx=1, PENABLE=0.
  - PADDR, PPROT, PWRITE and PWDATA take the captured values.
  - PSTRB = captured strb when writing; forced to 0 on reads (APB4 rule).
  - Go to ACCESS.
- ACCESS:
  - PSELx=1, PENABLE=1; all APB outputs held stable.
  - PREADY=0: remain in ACCESS (wait state).
  - PREADY=1: sample PRDATA (reads only, else 0) and PSLVERR into rsp_rdata/rsp_err, drop PSELx and PENABLE next cycle, go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err held stable.
  - On rsp_ready, go to IDLE.
- Outstanding transfers: at most one; cmd_ready=0 in every state other than IDLE.
- Latency with no wait states: handshake at cycle N, SETUP at N+1, ACCESS at N+2, rsp_valid at N+3. Minimum cmd-to-cmd spacing is 4 cycles.
- Idle bus values: PADDR, PWDATA and PWRITE keep their last values when PSELx=0. PSTRB returns to 0.
- A held response (rsp_ready=0) stalls the bridge indefinitely; no new command is accepted meanwhile.
- PSLVERR is ignored unless sampled together with PREADY=1 in ACCESS.

Optional Feature:
- Macro: APB_MST_TIMEOUT_EN.
- Defined:
  - A wait counter (width clog2(TIMEOUT_CYCLES+1)) clears on entering ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the counter reaches TIMEOUT_CYCLES, the transfer aborts: PSELx and PENABLE drop, go to RESP with rsp_err=1 and rsp_rdata=0.
  - A PREADY=1 arriving in the same cycle the count is reached takes priority (normal completion).
- Undefined: no counter exists, and ACCESS waits forever for PREADY.

Decomposition:
- Package apb4_mst_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS/RESP);
  - the command struct (write, addr, wdata, strb, prot);
  - the response struct (rdata, err);
  - default width constants.
- No sub-module; the timeout counter is inline under the macro.

Test Plan:
- Write, addr 0x0000_0010, wdata 0xDEAD_BEEF, strb 0xF, PREADY tied 1 -> SETUP then ACCESS, one cycle each; PSTRB=0xF; rsp_valid at N+3 with rsp_err=0.
- Read, addr 0x20, slave returns PRDATA=0x1234_5678 after 3 wait states -> PENABLE high for 4 cycles, PSTRB=0, rsp_rdata=0x1234_5678.
- Write with PSLVERR=1 sampled with PREADY -> rsp_err=1, rsp_rdata=0; PSLVERR=1 while PREADY=0 is ignored.
- rsp_ready held 0 for 5 cycles while cmd_valid=1 -> cmd_ready stays 0, PSELx stays 0, response stable, next transfer starts only after rsp_ready.
- PRESETn pulsed low during ACCESS -> PSELx, PENABLE and rsp_valid drop without waiting for PCLK; after release, the FSM is in IDLE with cmd_ready=1.
- With APB_MST_TIMEOUT_EN and TIMEOUT_CYCLES=4, PREADY never asserted -> abort after 4 wait cycles, rsp_err=1, rsp_rdata=0.
